// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - request/result bundle between a producer and the bin2bcd_seq converter
interface bin2bcd_seq_if #(
    parameter int IN_W   = 8,
    parameter int DIGITS = 3
);
    logic [IN_W-1:0]     bin_in;
    logic                in_valid;
    logic                in_ready;
    logic [4*DIGITS-1:0] bcd_out;
    logic                out_valid;
    logic [DIGITS-1:0]   digit_blank;

    modport master (
        output bin_in, in_valid,
        input  in_ready, bcd_out, out_valid, digit_blank
    );

    modport slave (
        input  bin_in, in_valid,
        output in_ready, bcd_out, out_valid, digit_blank
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter, one shift per clock
// Optional leading-zero blanking mask enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq #(
    parameter int IN_W   = 8,
    parameter int DIGITS = 3
) (
    input  logic         clock_100Mhz,
    input  logic         reset_n,
    bin2bcd_seq_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            r_state;
    logic [IN_W-1:0]   r_shift;
    logic [BCD_W-1:0]  r_scratch;
    logic [CNT_W-1:0]  r_count;
    logic [BCD_W-1:0]  r_bcd_out;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [DIGITS-1:0] r_digit_blank;

    logic [BCD_W-1:0]  w_adj;
    logic [DIGITS-1:0] w_blank;

    // Add-3 correction on every scratch digit that would overflow past 9 when doubled
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

`ifdef BIN2BCD_BLANK_EN
    logic w_upper_zero;

    // Leading-zero mask: digit i>0 blanks when it and every digit above it are zero
    always_comb begin
        w_blank      = '0;
        w_upper_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            w_upper_zero = w_upper_zero & (r_scratch[4*i +: 4] == 4'd0);
            w_blank[i]   = w_upper_zero;
        end
    end
`else
    assign w_blank = '0;
`endif

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_scratch     <= '0;
            r_count       <= '0;
            r_bcd_out     <= '0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_digit_blank <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_shift    <= bus.bin_in;
                        r_scratch  <= '0;
                        r_count    <= CNT_W'(IN_W);
                        r_in_ready <= 1'b0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    {r_scratch, r_shift} <= {w_adj, r_shift} << 1;
                    r_count              <= r_count - 1'b1;
                    if (r_count == CNT_W'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_bcd_out     <= r_scratch;
                    r_digit_blank <= w_blank;
                    r_out_valid   <= 1'b1;
                    r_in_ready    <= 1'b1;
                    r_state       <= IDLE;
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.bcd_out     = r_bcd_out;
    assign bus.out_valid   = r_out_valid;
    assign bus.digit_blank = r_digit_blank;
endmodule
